// File: rtl/output_packetizer_if.sv
// Stream bundle between the FFT output accumulator, the packetizer and the S2MM DMA port.
// slave is the packetizer's view; master is the view of the logic on either side of it.
interface output_packetizer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;
    logic              o_data_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_data_valid;
    logic              o_data_last;
    logic              i_data_ready;

    modport master (
        output i_data, i_data_valid, i_data_ready,
        input  o_data_ready, o_data, o_data_valid, o_data_last
    );

    modport slave (
        input  i_data, i_data_valid, i_data_ready,
        output o_data_ready, o_data, o_data_valid, o_data_last
    );
endinterface

// File: rtl/output_packetizer.sv
// Frames the accumulated FFT stream into FRAME_LEN-beat packets behind a 2-entry skid buffer.
// Define OUT_PKT_HDR_EN to prefix every packet with a {16'hFF7A, frame count} header word.
module output_packetizer #(
    parameter int FRAME_LEN = 256,
    parameter int DATA_W    = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output_packetizer_if.slave bus,
    output logic [15:0]        o_frame_cnt,
    output logic               o_busy
);
    localparam int               CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
`ifdef OUT_PKT_HDR_EN
    localparam logic [15:0]      HDR_TAG   = 16'hFF7A;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              in_acc, out_acc, out_free, word_avail;
    logic              load_data, load_hdr;
    logic [DATA_W-1:0] head_data;

    assign in_acc     = bus.i_data_valid & ready_q;
    assign out_acc    = out_valid_q & bus.i_data_ready;
    assign out_free   = ~out_valid_q | out_acc;
    assign word_avail = skid_valid_q | in_acc;
    // The skid entry always holds the oldest word, so it drains before the input port.
    assign head_data  = skid_valid_q ? skid_data_q : bus.i_data;

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        load_data    = 1'b0;
        load_hdr     = 1'b0;

        if (out_acc) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (out_free && word_avail) begin
`ifdef OUT_PKT_HDR_EN
            load_hdr  = (state_q != HDR) && (beat_cnt_q == '0);
            load_data = ~load_hdr;
`else
            load_data = 1'b1;
`endif
        end

        if (load_data) begin
            // ready is low whenever the skid entry is full, so it is always empty after this load
            out_valid_d  = 1'b1;
            out_data_d   = head_data;
            out_last_d   = (beat_cnt_q == LAST_BEAT);
            skid_valid_d = 1'b0;
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d = '0;
                state_d    = bus.i_data_valid ? DATA : IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
                state_d    = DATA;
            end
        end else if (load_hdr) begin
`ifdef OUT_PKT_HDR_EN
            // frame_cnt_d already includes a last beat retiring on this same edge
            out_data_d = DATA_W'({HDR_TAG, frame_cnt_d});
`endif
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            state_d     = HDR;
            if (in_acc) begin
                skid_valid_d = 1'b1;
                skid_data_d  = bus.i_data;
            end
        end else if (in_acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.i_data;
        end

        ready_d = ~skid_valid_d;
        busy_d  = (beat_cnt_d != '0) | out_valid_d | skid_valid_d;
    end

    // NOTE: the data registers are reset too; they are plain flops, not a memory array.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.o_data       = out_data_q;
    assign bus.o_data_valid = out_valid_q;
    assign bus.o_data_last  = out_last_q;
    assign bus.o_data_ready = ready_q;
    assign o_frame_cnt      = frame_cnt_q;
    assign o_busy           = busy_q;
endmodule

// File: tb/tb_output_packetizer.sv
// Scoreboard bench for output_packetizer: a frame-level model queues expected beats on input
// accept and a separate monitor pops and compares them on every output accept.
module tb_output_packetizer;
    localparam int FRAME_LEN = 256;
`ifdef OUT_PKT_HDR_EN
    localparam bit HDR_MODE  = 1'b1;
    localparam int STALL_ACC = 1;
`else
    localparam bit HDR_MODE  = 1'b0;
    localparam int STALL_ACC = 2;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          acc_edge;
        bit          is_hdr;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] frame_cnt;
    logic        busy;

    item_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_words = 0;
    int          beat = 0;
    logic [15:0] frames_queued = '0;
    logic [15:0] exp_fc = '0;
    bit          chk_lat = 1'b0;
    bit          wrap_req = 1'b0;
    int          ready_mode = 1;

    output_packetizer_if #(.DATA_W(32)) bus ();

    output_packetizer #(.FRAME_LEN(FRAME_LEN), .DATA_W(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus.slave),
        .o_frame_cnt (frame_cnt),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.i_data_ready = 1'b0;
            1:       bus.i_data_ready = 1'b1;
            default: bus.i_data_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Model: word n of a frame is last when n == FRAME_LEN-1; header mode prefixes each frame.
    always @(negedge clk) begin
        item_t it;
        if (!rst_n) begin
            acc_words     = 0;
            frames_queued = '0;
        end else begin
            if (wrap_req) frames_queued = 16'hFFFF;
            if (bus.i_data_valid && bus.o_data_ready) begin
                beat = acc_words % FRAME_LEN;
                if (HDR_MODE && beat == 0) begin
                    it = '{data: {16'hFF7A, frames_queued}, last: 1'b0, acc_edge: cyc + 1, is_hdr: 1'b1};
                    sb.push_back(it);
                end
                it = '{data: bus.i_data, last: (beat == FRAME_LEN - 1), acc_edge: cyc + 1, is_hdr: 1'b0};
                sb.push_back(it);
                if (beat == FRAME_LEN - 1) frames_queued = frames_queued + 16'd1;
                acc_words++;
            end
        end
    end

    always @(negedge clk) begin
        item_t e;
        if (!rst_n) begin
            sb.delete();
            exp_fc = '0;
        end else begin
            if (wrap_req) exp_fc = 16'hFFFF;
            if (!bus.o_data_ready) check("ready_low_needs_two_held", (sb.size() >= 2) ? 1 : 0, 1);
            if (bus.o_data_valid && !bus.i_data_ready && sb.size() > 0) begin
                check("stall_hold_data", bus.o_data, sb[0].data);
                check("stall_hold_last", bus.o_data_last, sb[0].last);
            end
            if (bus.o_data_valid && bus.i_data_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected nothing (cycle %0d)", bus.o_data, cyc);
                end else begin
                    e = sb.pop_front();
                    check("out_data", bus.o_data, e.data);
                    check("out_last", bus.o_data_last, e.last);
                    check("frame_cnt_at_accept", frame_cnt, exp_fc);
                    if (chk_lat && !e.is_hdr && !HDR_MODE) check("latency_edge", cyc, e.acc_edge);
                    if (e.last) exp_fc = exp_fc + 16'd1;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge (or after the budget).
    task automatic try_send(input logic [31:0] w, input int budget, output bit ok);
        ok = 1'b0;
        bus.i_data       = w;
        bus.i_data_valid = 1'b1;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            ok = bus.o_data_ready;
            @(posedge clk);
            #1;
        end
        bus.i_data_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        bit ok;
        try_send(w, 300, ok);
        if (!ok) fail_timeout("send_accept");
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !bus.o_data_valid;
        end
        if (!done) fail_timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] stall_w[3];
        bit          ok;
        int          n_acc;

        bus.i_data       = '0;
        bus.i_data_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.o_data_valid, 0);
        check("rst_last", bus.o_data_last, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.o_data_ready, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_before_first_edge", bus.o_data_ready, 0);
        @(posedge clk);
        #1 check("ready_after_first_edge", bus.o_data_ready, 1);

        // Streaming: 512 incrementing words at full rate.
        chk_lat = 1'b1;
        for (int i = 0; i < 512; i++) send(32'(i));
        wait_drain(100);
        check("stream_frame_cnt", frame_cnt, 2);
        check("stream_idle_busy", busy, 0);

        // Frame counter wrap: preset to 0xFFFF, then one more frame.
        wrap_req = 1'b1;
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        wrap_req = 1'b0;
        check("preset_frame_cnt", frame_cnt, 16'hFFFF);
        for (int i = 0; i < FRAME_LEN; i++) send($urandom);
        wait_drain(100);
        check("wrap_frame_cnt", frame_cnt, 16'h0000);

        // Backpressure: random downstream ready and random input gaps.
        chk_lat    = 1'b0;
        ready_mode = 2;
        for (int i = 0; i < FRAME_LEN; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send($urandom);
        end
        wait_drain(2000);
        check("backpressure_frame_cnt", frame_cnt, 16'h0001);

        // Mid-frame reset after 100 beats.
        ready_mode = 1;
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        for (int i = 0; i < 100; i++) send(32'h1000_0000 + 32'(i));
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.o_data_valid, 0);
        check("midrst_last", bus.o_data_last, 0);
        check("midrst_data", bus.o_data, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", bus.o_data_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check("midrst_ready_back", bus.o_data_ready, 1);
        for (int i = 0; i < FRAME_LEN; i++) send(32'h2000_0000 + 32'(i));
        wait_drain(100);
        check("post_reset_frame_cnt", frame_cnt, 1);

        // Full stall: downstream ready held low, three words offered.
        chk_lat    = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) stall_w[k] = $urandom;
        n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            try_send(stall_w[k], 4, ok);
            if (!ok) break;
            n_acc++;
            if (n_acc == STALL_ACC) begin
                @(negedge clk);
                check("stall_ready_drop", bus.o_data_ready, 0);
                @(posedge clk);
                #1;
            end
        end
        check("stall_accepted", n_acc, STALL_ACC);
        @(negedge clk);
        check("stall_valid", bus.o_data_valid, 1);
        check("stall_head_data", bus.o_data, (sb.size() > 0) ? sb[0].data : 32'hDEAD_BEEF);
        check("stall_busy", busy, 1);
        @(posedge clk);
        #1;
        ready_mode = 1;
        for (int k = n_acc; k < 3; k++) send(stall_w[k]);
        wait_drain(100);
        check("partial_frame_busy", busy, 1);
        check("partial_frame_cnt", frame_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
